lgn_pattern_streamer: RTL and testbench
=======================================

// Module: lgn_pattern_streamer
// PURPOSE
//  Parametrised stimulus sequencer for the LGN MNIST core on FPGA boards. Holds NUM_PATTERNS
//  writable images and streams one image, BYTE_W bits per clk, into the core's ui_in.
//  After RESULT_LATENCY cycles it captures the core's class index into a held result.
//  Patterns are selected by button, by auto-cycle timer, or directly; supersedes the fixed-ROM feeder.
// PARAMETERS
//  NUM_PATTERNS     4           images stored; PSEL_W = $clog2(NUM_PATTERNS), minimum 1
//  BYTES_PER_IMAGE  32          beats per image; BEAT_W = $clog2(BYTES_PER_IMAGE)
//  BYTE_W           8           data bits per beat
//  IDX_W            4           class index width from the core
//  RESULT_LATENCY   2           cycles from the last beat to a valid core index (0..15)
//  AUTO_PERIOD      12000000    clk cycles between auto-advances (>=2)
// PORTS
//  clk          in   1                          system clock
//  rst          in   1                          asynchronous, active-high reset
//  auto_en      in   1                          1 = advance the pattern every AUTO_PERIOD
//  next_btn     in   1                          raw button; each synchronised rising edge advances
//  sel_valid    in   1                          direct select strobe
//  sel_pattern  in   PSEL_W                     pattern for sel_valid
//  wr_en        in   1                          pattern memory write
//  wr_addr      in   PSEL_W+BEAT_W              {pattern, beat}
//  wr_data      in   BYTE_W                     write data
//  core_index   in   IDX_W                      the core's uio_out index
//  stream_data  out  BYTE_W                     goes to the core's ui_in
//  stream_valid out  1                          high during image beats
//  frame_start  out  1                          high on beat 0 only
//  cur_pattern  out  PSEL_W                     pattern currently selected
//  result_index out  IDX_W                      last captured class
//  result_valid out  1                          one-cycle pulse when result_index updates
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; cur_pattern=0; timer=0; synchroniser flops=0.
//  Memory contents are not reset (synchronous RAM, 1-cycle read).
//  FSM: IDLE -> STREAM once any advance/select/start condition holds (reset release counts as start).
//   STREAM: BYTES_PER_IMAGE beats; beat k presents mem[cur_pattern][k]; frame_start on k=0.
//   Read latency is hidden by prefetch, so beats are back-to-back with no bubbles.
//   STREAM -> DRAIN after the last beat; DRAIN counts RESULT_LATENCY cycles; stream_data=0.
//   DRAIN -> CAPTURE: result_index<=core_index, result_valid=1 for 1 cycle.
//   CAPTURE -> STREAM (next frame, same or newly selected pattern) on the following cycle.
//  Continuous loop: frame period = BYTES_PER_IMAGE + RESULT_LATENCY + 1 cycles.
//  Pattern change (btn edge, sel_valid, or timer expiry) is recorded pending and applied only
//   at frame boundaries (CAPTURE->STREAM); a frame never mixes two patterns.
//  Priority on a simultaneous change: sel_valid > next_btn > timer. At most one advance per frame;
//   extra events in the same frame are dropped.
//  Advance: cur_pattern+1, wrapping from NUM_PATTERNS-1 to 0.
//  sel_pattern >= NUM_PATTERNS is ignored.
//  next_btn: 2-flop synchroniser, then rising-edge detect; no debounce (external).
//  Timer: counts only while auto_en=1; resets to 0 on expiry and whenever auto_en=0.
//  Write to the pattern currently streaming: write takes effect; a beat read in the same cycle
//   returns old data (read-before-write). Writes to other patterns are unrestricted.
//  Reset mid-frame: immediate abort; outputs 0; no result_valid pulse.
// STRUCTURE
//  Package lgn_stream_pkg: state enum {IDLE,STREAM,DRAIN,CAPTURE}; PSEL_W/BEAT_W derivation functions.
//  Sub-module lgn_pattern_mem: 1R1W sync RAM, NUM_PATTERNS*BYTES_PER_IMAGE x BYTE_W, infers iCE40 BRAM.
//  Top holds the FSM, beat/drain counters, auto timer, button sync, and result register.
// TESTING
//  1 Load pattern 0 with beat k=k; release rst -> frame_start at the first beat; data 0..31 on
//    32 consecutive cycles; result_valid exactly 35 cycles after frame_start (default params).
//  2 core_index=4'd5 driven during DRAIN -> result_index=5 with a single result_valid pulse;
//    result_index holds through the next frame.
//  3 Pulse next_btn mid-frame on pattern 3 -> current frame stays pattern 3;
//    next frame streams pattern 0 (wrap); cur_pattern=0.
//  4 AUTO_PERIOD=50 with auto_en=1 -> the pattern advances every ~50 cycles at frame boundaries only;
//    sel_valid=2 coinciding with timer expiry -> pattern 2 wins.
//  5 Write beat 10 of the streaming pattern in the same cycle it is read -> old value output;
//    the next frame shows the new value.
//  6 Assert rst at beat 17 -> all outputs 0 asynchronously; no result_valid;
//    after release, a fresh frame starts at beat 0 with pattern 0.

Source files
------------

// File: rtl/lgn_stream_pkg.sv
// Shared types and width helpers for the LGN pattern streamer.
package lgn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    DRAIN   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Pattern-select width; never narrower than one bit.
  function automatic int psel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Beat-counter width; never narrower than one bit.
  function automatic int beat_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lgn_pattern_streamer_if.sv
// Control, pattern-load and stream signals of the LGN pattern streamer.
// Handshake: stream_valid qualifies stream_data every cycle with no back-pressure;
// result_valid is a one-cycle pulse marking a fresh result_index; sel_valid and
// wr_en are single-cycle strobes sampled on the rising clock edge.
interface lgn_pattern_streamer_if #(
  parameter int PSEL_W = 2,
  parameter int BEAT_W = 5,
  parameter int BYTE_W = 8,
  parameter int IDX_W  = 4
);
  import lgn_stream_pkg::*;

  logic                     auto_en;
  logic                     next_btn;
  logic                     sel_valid;
  logic [PSEL_W-1:0]        sel_pattern;
  logic                     wr_en;
  logic [PSEL_W+BEAT_W-1:0] wr_addr;
  logic [BYTE_W-1:0]        wr_data;
  logic [IDX_W-1:0]         core_index;
  logic [BYTE_W-1:0]        stream_data;
  logic                     stream_valid;
  logic                     frame_start;
  logic [PSEL_W-1:0]        cur_pattern;
  logic [IDX_W-1:0]         result_index;
  logic                     result_valid;
  state_t                   dbg_state;

  modport master (
    output auto_en, next_btn, sel_valid, sel_pattern, wr_en, wr_addr, wr_data, core_index,
    input  stream_data, stream_valid, frame_start, cur_pattern, result_index, result_valid,
           dbg_state
  );

  modport slave (
    input  auto_en, next_btn, sel_valid, sel_pattern, wr_en, wr_addr, wr_data, core_index,
    output stream_data, stream_valid, frame_start, cur_pattern, result_index, result_valid,
           dbg_state
  );

endinterface

// File: rtl/lgn_pattern_mem.sv
// 1R1W synchronous pattern RAM with a one-cycle registered read (BRAM friendly).
module lgn_pattern_mem #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  // Write and read share the edge; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_q <= mem_q[raddr_i];
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/lgn_pattern_streamer.sv
// Streams stored images into the LGN core back-to-back and captures its class index.
module lgn_pattern_streamer
  import lgn_stream_pkg::*;
#(
  parameter int NUM_PATTERNS    = 4,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int BYTE_W          = 8,
  parameter int IDX_W           = 4,
  parameter int RESULT_LATENCY  = 2,
  parameter int AUTO_PERIOD     = 12000000
) (
  input logic                  clk,
  input logic                  rst,
  lgn_pattern_streamer_if.slave bus
);

  localparam int PSEL_W = psel_w(NUM_PATTERNS);
  localparam int BEAT_W = beat_w(BYTES_PER_IMAGE);
  localparam int AW     = PSEL_W + BEAT_W;
  localparam int TMR_W  = $clog2(AUTO_PERIOD);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BYTES_PER_IMAGE - 1);
  localparam logic [3:0]        LAST_DRAIN = 4'((RESULT_LATENCY > 0) ? RESULT_LATENCY - 1 : 0);
  localparam logic [PSEL_W-1:0] LAST_PAT   = PSEL_W'(NUM_PATTERNS - 1);
  localparam logic [TMR_W-1:0]  LAST_TICK  = TMR_W'(AUTO_PERIOD - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [3:0]        drain_q, drain_d;
  logic [PSEL_W-1:0] cur_q, cur_d;
  logic              pend_valid_q, pend_valid_d;
  logic [PSEL_W-1:0] pend_pat_q, pend_pat_d;
  logic [TMR_W-1:0]  timer_q;
  logic              btn_s1_q, btn_s2_q, btn_s3_q;
  logic [IDX_W-1:0]  result_index_q;
  logic              result_valid_q;
  logic [BYTE_W-1:0] rd_data;

  logic              sel_ok, btn_rise, tmr_exp, ev_valid;
  logic [PSEL_W-1:0] adv_pat, ev_pat;

  // Pattern-change sources, highest priority first: direct select, button, timer.
  always_comb begin
    sel_ok   = bus.sel_valid && (int'(bus.sel_pattern) < NUM_PATTERNS);
    btn_rise = btn_s2_q && !btn_s3_q;
    tmr_exp  = bus.auto_en && (timer_q == LAST_TICK);
    adv_pat  = (cur_q == LAST_PAT) ? '0 : cur_q + 1'b1;
    ev_valid = sel_ok || btn_rise || tmr_exp;
    ev_pat   = sel_ok ? bus.sel_pattern : adv_pat;
  end

  // Next-state, beat/drain counting and frame-boundary pattern switching.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    cur_d        = cur_q;
    pend_valid_d = pend_valid_q;
    pend_pat_d   = pend_pat_q;
    case (state_q)
      IDLE: begin
        state_d = STREAM;
        beat_d  = '0;
      end
      STREAM: begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (RESULT_LATENCY == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = CAPTURE;
        else                       drain_d = drain_q + 4'd1;
      end
      CAPTURE: begin
        state_d = STREAM;
        beat_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // Only the first change in a frame is kept; it lands on the CAPTURE->STREAM edge.
    if (state_q == CAPTURE) begin
      pend_valid_d = 1'b0;
      if (pend_valid_q)  cur_d = pend_pat_q;
      else if (ev_valid) cur_d = ev_pat;
    end else if (!pend_valid_q && ev_valid) begin
      pend_valid_d = 1'b1;
      pend_pat_d   = ev_pat;
    end
  end

  // FSM, counters and pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      drain_q      <= '0;
      cur_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_pat_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      cur_q        <= cur_d;
      pend_valid_q <= pend_valid_d;
      pend_pat_q   <= pend_pat_d;
    end
  end

  // Auto-advance timer: free-runs only while enabled, restarts on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer_q <= '0;
    else if (!bus.auto_en)      timer_q <= '0;
    else if (timer_q == LAST_TICK) timer_q <= '0;
    else                        timer_q <= timer_q + 1'b1;
  end

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
    end else begin
      btn_s1_q <= bus.next_btn;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
    end
  end

  // Result register: sample the core index in CAPTURE and pulse valid once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_index_q <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= (state_q == CAPTURE);
      if (state_q == CAPTURE) result_index_q <= bus.core_index;
    end
  end

  // Read address follows next-cycle beat and pattern, hiding the RAM latency.
  lgn_pattern_mem #(.AW(AW), .DW(BYTE_W)) u_mem (
    .clk     (clk),
    .we_i    (bus.wr_en),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i ({cur_d, beat_d}),
    .rdata_o (rd_data)
  );

  assign bus.stream_valid = (state_q == STREAM);
  assign bus.frame_start  = (state_q == STREAM) && (beat_q == '0);
  assign bus.stream_data  = (state_q == STREAM) ? rd_data : '0;
  assign bus.cur_pattern  = cur_q;
  assign bus.result_index = result_index_q;
  assign bus.result_valid = result_valid_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_lgn_pattern_streamer.sv
// Directed scoreboard bench for lgn_pattern_streamer.
module tb_lgn_pattern_streamer;
  import lgn_stream_pkg::*;

  localparam int NP  = 4;
  localparam int BPI = 32;
  localparam int BW  = 8;
  localparam int IW  = 4;
  localparam int RL  = 2;
  localparam int AP  = 50;
  localparam int PW  = 2;
  localparam int BTW = 5;
  localparam int AW  = PW + BTW;
  localparam int FRAME = BPI + RL + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  lgn_pattern_streamer_if #(.PSEL_W(PW), .BEAT_W(BTW), .BYTE_W(BW), .IDX_W(IW)) bus ();

  lgn_pattern_streamer #(
    .NUM_PATTERNS(NP), .BYTES_PER_IMAGE(BPI), .BYTE_W(BW), .IDX_W(IW),
    .RESULT_LATENCY(RL), .AUTO_PERIOD(AP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0]      mem_m [0:NP*BPI-1];
  logic [PW+BW:0]     exp_q[$];   // {frame_start, pattern, data}
  logic [IW-1:0]      res_q[$];
  logic [IW-1:0]      last_res = '0;
  int                 last_fs = 0;
  int                 checks = 0;
  int                 failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [PW+BW:0] e;
    logic [IW-1:0]  r;
    if (!rst) begin
      if (bus.result_valid) begin
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL result_unexpected got=%0h expected=none (cycle %0d)", bus.result_index, cyc);
        end else begin
          r = res_q.pop_front();
          check("result_index", bus.result_index, r);
          last_res = r;
        end
        check("result_latency", cyc - last_fs, FRAME);
      end else begin
        check("result_hold", bus.result_index, last_res);
      end
      if (bus.stream_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected got=%0h expected=none (cycle %0d)", bus.stream_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat", {bus.frame_start, bus.cur_pattern, bus.stream_data}, e);
        end
        if (bus.frame_start) last_fs = cyc;
      end else begin
        check("idle_outputs", {bus.frame_start, bus.stream_data}, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called one step after the edge that shows beat 0 of a frame.
  task automatic run_frame(input int pat, input logic [IW-1:0] idx, input logic auto,
                           input int btn_at, input int sel_at, input logic [PW-1:0] sel_val,
                           input int wr_at, input logic [AW-1:0] wa, input logic [BW-1:0] wd);
    for (int k = 0; k < BPI; k++)
      exp_q.push_back({(k == 0), PW'(pat), mem_m[pat*BPI + k]});
    res_q.push_back(idx);
    bus.core_index = ~idx;
    for (int c = 0; c < FRAME; c++) begin
      bus.auto_en     = auto;
      bus.next_btn    = (btn_at >= 0) && (c >= btn_at) && (c < btn_at + 3);
      bus.sel_valid   = (c == sel_at);
      bus.sel_pattern = sel_val;
      bus.wr_en       = (c == wr_at);
      bus.wr_addr     = wa;
      bus.wr_data     = wd;
      if (c == BPI) bus.core_index = idx;
      @(posedge clk); #1;
      if (c == wr_at) mem_m[wa] = wd;
    end
    bus.next_btn  = 1'b0;
    bus.sel_valid = 1'b0;
    bus.wr_en     = 1'b0;
  endtask

  task automatic partial_frame(input int pat, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      exp_q.push_back({(k == 0), PW'(pat), mem_m[pat*BPI + k]});
    repeat (nbeats) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stream_valid"}, bus.stream_valid, 0);
    check({tag, "_stream_data"},  bus.stream_data, 0);
    check({tag, "_frame_start"},  bus.frame_start, 0);
    check({tag, "_cur_pattern"},  bus.cur_pattern, 0);
    check({tag, "_result_index"}, bus.result_index, 0);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_state"},        bus.dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.auto_en = 0; bus.next_btn = 0; bus.sel_valid = 0; bus.sel_pattern = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.core_index = '0;
    for (int a = 0; a < NP*BPI; a++) mem_m[a] = BW'(a);
    repeat (2) @(posedge clk); #1;
    for (int a = 0; a < NP*BPI; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = mem_m[a];
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
    check_reset_outputs("reset");

    rst = 1'b0;
    @(posedge clk); #1;
    // pattern 0 ramp, index 5, then a frame that selects pattern 3
    run_frame(0, 4'd5,  1'b0, -1, -1, 2'd0, -1, '0, '0);
    run_frame(0, 4'd9,  1'b0, -1, 10, 2'd3, -1, '0, '0);
    // button mid-frame on pattern 3 wraps to 0 next frame
    run_frame(3, 4'd3,  1'b0, 12, -1, 2'd0, -1, '0, '0);
    // write beat 10 of the streaming pattern on the edge that reads it
    run_frame(0, 4'd12, 1'b0, -1, -1, 2'd0, 9, 7'd10, 8'hC3);
    run_frame(0, 4'd7,  1'b0, -1, -1, 2'd0, -1, '0, '0);
    // auto-advance every 50 cycles; expiries fall in frames 6, 7, 9 (with select 2), 10
    run_frame(0, 4'd1,  1'b1, -1, -1, 2'd0, -1, '0, '0);
    run_frame(0, 4'd2,  1'b1, -1, -1, 2'd0, -1, '0, '0);
    run_frame(1, 4'd4,  1'b1, -1, -1, 2'd0, -1, '0, '0);
    run_frame(2, 4'd6,  1'b1, -1, -1, 2'd0, -1, '0, '0);
    run_frame(2, 4'd8,  1'b1, -1,  9, 2'd2, -1, '0, '0);
    run_frame(2, 4'd10, 1'b1, -1, -1, 2'd0, -1, '0, '0);
    run_frame(3, 4'd11, 1'b0, -1, -1, 2'd0, -1, '0, '0);

    // abort at beat 17
    bus.core_index = 4'hE;
    partial_frame(3, 17);
    rst = 1'b1;
    last_res = '0;
    #1;
    check_reset_outputs("abort");
    check("abort_beats_left", exp_q.size(), 0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 4'd13, 1'b0, -1, -1, 2'd0, -1, '0, '0);
    partial_frame(0, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("end_beats_left", exp_q.size(), 0);
    check("end_results_left", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
